mem_read_port: RTL and testbench

//   Read-side counterpart to the 32-bit write-enabled register path. Accepts a load

---
 rtl/mem_read_port_if.sv | 30 +++
 rtl/mem_read_port.sv | 147 ++++++++++++++
 tb/tb_mem_read_port.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_port_if.sv
// Load-port bundle: datapath request/response and the word-wide data memory read bus.
// The master side is the datapath together with the memory. The slave side is the read port.
// Handshake: Req is taken on a rising edge only while Busy=0. Each accepted legal request
// gives one Mem_RE cycle. Every request taken ends in exactly one Valid pulse, with Err
// set when the request was rejected. A Req seen while Busy=1 is dropped.
interface mem_read_port_if #(
    parameter int ADDR_W = 12
);
    logic              Req;
    logic [ADDR_W-1:0] Addr;
    logic [1:0]        Size;
    logic              Unsigned;
    logic              Mem_RE;
    logic [ADDR_W-3:0] Mem_Addr;
    logic [31:0]       Mem_Data;
    logic              Busy;
    logic              Valid;
    logic              Err;
    logic [31:0]       Dout;

    modport master (
        output Req, Addr, Size, Unsigned, Mem_Data,
        input  Mem_RE, Mem_Addr, Busy, Valid, Err, Dout
    );

    modport slave (
        input  Req, Addr, Size, Unsigned, Mem_Data,
        output Mem_RE, Mem_Addr, Busy, Valid, Err, Dout
    );
endinterface

// File: rtl/mem_read_port.sv
// Load read port. It issues a single read strobe to a fixed-latency data memory.
// It then extracts the addressed byte, half or word from the returned word and
// extends it. The result is presented on a held Dout with a one-cycle Valid pulse.
module mem_read_port #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mem_read_port_if.slave      bus,
    output logic [1:0]          state_dbg_o
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       dout_q;

    logic              accept;
    logic              legal;
    logic              capture;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext_data;

    // A new request can be taken in any state except WAIT. This covers back-to-back issue from DONE/ERR.
    assign accept  = bus.Req && (state_q != WAIT);
    // Memory data is valid in the final WAIT cycle, which is when the counter reaches zero.
    assign capture = (state_q == WAIT) && (cnt_q == '0);

    // Classify the incoming request: the size must be legal and the address naturally aligned.
    always_comb begin
        legal = 1'b0;
        case (bus.Size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~bus.Addr[0];
            2'b10:   legal = (bus.Addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // State register and latency down-counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. WAIT spans LATENCY+1 cycles: counter goes LATENCY..0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (accept) begin
                    if (legal) begin
                        state_d = WAIT;
                        cnt_d   = LAT_C;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Latch the request attributes when the request is accepted, so later input changes cannot disturb the access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_addr_q <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
        end else if (accept && legal) begin
            mem_addr_q <= bus.Addr[ADDR_W-1:2];
            lane_q     <= bus.Addr[1:0];
            size_q     <= bus.Size;
            uns_q      <= bus.Unsigned;
        end
    end

    // Little-endian lane extraction followed by sign or zero extension.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ext_data = 32'h0000_0000;
        case (lane_q)
            2'd0:    byte_sel = bus.Mem_Data[7:0];
            2'd1:    byte_sel = bus.Mem_Data[15:8];
            2'd2:    byte_sel = bus.Mem_Data[23:16];
            default: byte_sel = bus.Mem_Data[31:24];
        endcase
        half_sel = lane_q[1] ? bus.Mem_Data[31:16] : bus.Mem_Data[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   ext_data = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: ext_data = bus.Mem_Data;
        endcase
    end

    // The result register changes only on a completed memory load. Error responses leave it as it was.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dout_q <= 32'h0000_0000;
        end else if (capture) begin
            dout_q <= ext_data;
        end
    end

    // Outputs decoded from state. The strobe is the first WAIT cycle, where the counter still holds LATENCY.
    always_comb begin
        bus.Mem_RE   = (state_q == WAIT) && (cnt_q == LAT_C);
        bus.Busy     = (state_q == WAIT);
        bus.Valid    = (state_q == DONE) || (state_q == ERR);
        bus.Err      = (state_q == ERR);
        bus.Mem_Addr = mem_addr_q;
        bus.Dout     = dout_q;
        state_dbg_o  = state_q;
    end

endmodule

// File: tb/tb_mem_read_port.sv
// Directed bench for mem_read_port at ADDR_W=12, LATENCY=2.
module tb_mem_read_port;

    localparam int ADDR_W = 12;
    localparam int LAT    = 2;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  state_dbg;
    logic [1:0]  re_pipe;
    logic [31:0] mem_word;
    int          n_checks;
    int          n_err;

    mem_read_port_if #(.ADDR_W(ADDR_W)) bus ();

    mem_read_port #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .bus         (bus.slave),
        .state_dbg_o (state_dbg)
    );

    // Clock generator.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Fixed-latency memory model. It drives data only in the cycle LAT cycles after the strobe.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) re_pipe <= 2'b00;
        else        re_pipe <= {re_pipe[0], bus.Mem_RE};
    end
    assign bus.Mem_Data = re_pipe[1] ? mem_word : 32'hA5A5_5A5A;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] word;
        logic        err;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one request from a negedge. Then check the control outputs cycle by cycle up to the Valid cycle.
    task automatic do_vec(input vec_t v);
        logic [3:0] exp_ctl;
        int         kmax;
        bus.Req      = 1'b1;
        bus.Addr     = v.addr;
        bus.Size     = v.size;
        bus.Unsigned = v.uns;
        mem_word     = v.word;
        @(posedge Clk);
        #1;
        bus.Req      = 1'b0;
        bus.Addr     = 12'($urandom_range(0, 4095));
        bus.Size     = 2'($urandom_range(0, 3));
        bus.Unsigned = 1'($urandom_range(0, 1));
        kmax = v.err ? 2 : LAT + 2;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge Clk);
            if (v.err)
                exp_ctl = {1'b0, 1'b0, (k == 1), (k == 1)};
            else
                exp_ctl = {(k == 1), (k <= LAT + 1), (k == LAT + 2), 1'b0};
            check($sformatf("%s ctl{re,busy,valid,err} c%0d", v.name, k),
                  32'({bus.Mem_RE, bus.Busy, bus.Valid, bus.Err}), 32'(exp_ctl));
            if (!v.err && k == 1)
                check({v.name, " mem_addr"}, 32'(bus.Mem_Addr), 32'(v.addr[11:2]));
            if (exp_ctl[1])
                check({v.name, " dout"}, bus.Dout, v.dout);
        end
    endtask

    initial begin
        int re_cnt;
        int val_cnt;
        int re_idx[3];
        vec_t rv;

        n_checks     = 0;
        n_err        = 0;
        mem_word     = 32'h0;
        bus.Req      = 1'b0;
        bus.Addr     = '0;
        bus.Size     = 2'b00;
        bus.Unsigned = 1'b0;

        vecs[0]  = '{"word_008",      12'h008, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[1]  = '{"byte3_signed",  12'h003, 2'b00, 1'b0, 32'h80F0_0F01, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{"byte3_uns",     12'h003, 2'b00, 1'b1, 32'h80F0_0F01, 1'b0, 32'h0000_0080};
        vecs[3]  = '{"byte0_signed",  12'h000, 2'b00, 1'b0, 32'h80F0_0F01, 1'b0, 32'h0000_0001};
        vecs[4]  = '{"byte1_uns",     12'h001, 2'b00, 1'b1, 32'h80F0_0F01, 1'b0, 32'h0000_000F};
        vecs[5]  = '{"byte2_signed",  12'h002, 2'b00, 1'b0, 32'h80F0_0F01, 1'b0, 32'hFFFF_FFF0};
        vecs[6]  = '{"half2_signed",  12'h002, 2'b01, 1'b0, 32'h8001_7FFF, 1'b0, 32'hFFFF_8001};
        vecs[7]  = '{"half0_signed",  12'h000, 2'b01, 1'b0, 32'h8001_7FFF, 1'b0, 32'h0000_7FFF};
        vecs[8]  = '{"half2_uns",     12'h002, 2'b01, 1'b1, 32'h8001_7FFF, 1'b0, 32'h0000_8001};
        vecs[9]  = '{"word_misalign", 12'h001, 2'b10, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_8001};
        vecs[10] = '{"size_11",       12'h004, 2'b11, 1'b0, 32'h2222_2222, 1'b1, 32'h0000_8001};
        vecs[11] = '{"half_misalign", 12'h001, 2'b01, 1'b1, 32'h3333_3333, 1'b1, 32'h0000_8001};
        vecs[12] = '{"word_top",      12'hFFC, 2'b10, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678};

        // Reset block.
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset ctl", 32'({bus.Mem_RE, bus.Busy, bus.Valid, bus.Err}), 32'h0);
        check("reset dout", bus.Dout, 32'h0);
        check("reset mem_addr", 32'(bus.Mem_Addr), 32'h0);
        check("reset state", 32'(state_dbg), 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            do_vec(vecs[i]);
            @(negedge Clk);
        end

        // Req held high for three loads: strobe every LAT+2 cycles.
        bus.Req = 1'b1; bus.Addr = 12'h010; bus.Size = 2'b10; bus.Unsigned = 1'b0;
        mem_word = 32'hCAFE_F00D;
        re_cnt = 0; val_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (bus.Mem_RE) begin
                if (re_cnt < 3) re_idx[re_cnt] = k;
                re_cnt++;
            end
            if (bus.Valid) val_cnt++;
            if (k == 12) bus.Req = 1'b0;
        end
        check("held_req re count", 32'(re_cnt), 32'd3);
        check("held_req valid count", 32'(val_cnt), 32'd3);
        check("held_req first re", 32'(re_idx[0]), 32'd1);
        check("held_req re spacing1", 32'(re_idx[1] - re_idx[0]), 32'(LAT + 2));
        check("held_req re spacing2", 32'(re_idx[2] - re_idx[1]), 32'(LAT + 2));
        check("held_req dout", bus.Dout, 32'hCAFE_F00D);
        repeat (2) @(negedge Clk);

        // Req pulses while Busy are dropped.
        bus.Req = 1'b1; bus.Addr = 12'h020; bus.Size = 2'b01; bus.Unsigned = 1'b1;
        mem_word = 32'hBEEF_1234;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        re_cnt = 0; val_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            if (bus.Mem_RE) re_cnt++;
            if (bus.Valid) val_cnt++;
            if (k == 1) bus.Req = 1'b1;
            if (k == 3) bus.Req = 1'b0;
        end
        check("busy_drop re count", 32'(re_cnt), 32'd1);
        check("busy_drop valid count", 32'(val_cnt), 32'd1);
        check("busy_drop dout", bus.Dout, 32'h0000_1234);

        // Reset in the middle of WAIT aborts the access.
        bus.Req = 1'b1; bus.Addr = 12'h044; bus.Size = 2'b10; bus.Unsigned = 1'b0;
        mem_word = 32'h0BAD_0BAD;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midreset ctl", 32'({bus.Mem_RE, bus.Busy, bus.Valid, bus.Err}), 32'h0);
        check("midreset dout", bus.Dout, 32'h0);
        check("midreset mem_addr", 32'(bus.Mem_Addr), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        val_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (bus.Valid || bus.Mem_RE) val_cnt++;
        end
        check("midreset no activity", 32'(val_cnt), 32'd0);
        rv = '{"after_reset", 12'h006, 2'b01, 1'b0, 32'hF00D_8765, 1'b0, 32'hFFFF_F00D};
        do_vec(rv);
        @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
